// File: rtl/writeback_unit_pkg.sv
// Shared types and widths for the register-file write-back side of the datapath.
package writeback_unit_pkg;

  localparam int REG_W            = 5;
  localparam int DATA_W           = 32;
  localparam int DEFAULT_LINK_REG = 31;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_timer.sv
// Saturating wait counter for outstanding loads; expired flags that this edge's
// increment reaches LIMIT.
module wb_load_timer #(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W:0]   ONE_X   = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   LIMIT_X = (CNT_W+1)'(LIMIT);

  logic [CNT_W-1:0] count;

  assign expired = ({1'b0, count} + ONE_X) >= LIMIT_X;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && ({1'b0, count} < LIMIT_X)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: selects destination and value for retiring
// instructions and holds loads until their data returns or the wait times out.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LINK_REG     = DEFAULT_LINK_REG,
  parameter int LOAD_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              MemOrIOToReg,
  input  logic              Jal,
  input  logic [DATA_W-1:0] Instruction,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] opcplus4,
  input  logic              mem_valid,
  input  logic [DATA_W-1:0] mem_or_io_data,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_dst,
  output logic [DATA_W-1:0] wb_data,
  output logic              pend_valid,
  output logic [REG_W-1:0]  pend_dst,
  output logic              load_timeout
);

  localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

  wb_state_e         state, state_nxt;
  logic              accept;
  logic [REG_W-1:0]  dst_sel;
  logic              wr_nxt, timeout_nxt;
  logic [REG_W-1:0]  dst_nxt, pend_dst_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              timer_clear, timer_en, timer_expired;
  logic              instr_unused;

  // Opcode, rs and shamt/funct fields play no part in write-back.
  assign instr_unused = ^{Instruction[31:21], Instruction[10:0]};

  assign in_ready   = (state == IDLE) && !reset;
  assign accept     = in_valid && in_ready;
  assign pend_valid = (state == WAIT_MEM);
  assign dst_sel    = Jal ? LINK_IDX : (RegDst ? Instruction[15:11] : Instruction[20:16]);

  wb_load_timer #(
    .LIMIT(LOAD_TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expired(timer_expired)
  );

  always_comb begin
    state_nxt    = state;
    wr_nxt       = 1'b0;
    timeout_nxt  = 1'b0;
    dst_nxt      = wb_dst;
    data_nxt     = wb_data;
    pend_dst_nxt = pend_dst;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept && RegWrite) begin
          if (!Jal && MemOrIOToReg) begin
            pend_dst_nxt = dst_sel;
            timer_clear  = 1'b1;
            state_nxt    = WAIT_MEM;
          end else if (dst_sel != '0) begin
            wr_nxt   = 1'b1;
            dst_nxt  = dst_sel;
            data_nxt = Jal ? opcplus4 : ALU_result;
          end
        end
      end
      WAIT_MEM: begin
        // Returning data takes priority over a timeout on the same edge.
        if (mem_valid) begin
          state_nxt = IDLE;
          if (pend_dst != '0) begin
            wr_nxt   = 1'b1;
            dst_nxt  = pend_dst;
            data_nxt = mem_or_io_data;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      wb_reg_write <= 1'b0;
      wb_dst       <= '0;
      wb_data      <= '0;
      pend_dst     <= '0;
      load_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      wb_reg_write <= wr_nxt;
      wb_dst       <= dst_nxt;
      wb_data      <= data_nxt;
      pend_dst     <= pend_dst_nxt;
      load_timeout <= timeout_nxt;
    end
  end

endmodule
